// File: rtl/fwd_scoreboard.sv
// Register-forwarding scoreboard: DEPTH-slot shift queue of in-flight writes, youngest-match forwarding.
// Forward/stall are combinational (0 cycles); retire is registered 1 cycle after ejection; hold_out freezes the queue.
module fwd_scoreboard #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int DEPTH       = 6,
  parameter int RD_PORTS    = 2,
  parameter int ZERO_REG_EN = 0,
  localparam int SLOT_W     = $clog2(DEPTH) + 1
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         advance_in,
  input  logic                         flush_in,
  input  logic                         issue_valid_in,
  input  logic                         issue_write_in,
  input  logic [REG_W-1:0]             issue_num_in,
  input  logic                         res_valid_in,
  input  logic [SLOT_W-1:0]            res_slot_in,
  input  logic [DATA_W-1:0]            res_data_in,
  input  logic [RD_PORTS*REG_W-1:0]    rd_num_in,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_reg_data_in,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_out,
  output logic [RD_PORTS-1:0]          rd_stall_out,
  output logic                         hold_out,
  output logic                         retire_valid_out,
  output logic [REG_W-1:0]             retire_num_out,
  output logic [DATA_W-1:0]            retire_data_out
);

  logic [DEPTH:1]    r_vld;
  logic [DEPTH:1]    r_wr;
  logic [DEPTH:1]    r_rdy;
  logic [REG_W-1:0]  r_num [1:DEPTH];
  logic [DATA_W-1:0] r_dat [1:DEPTH];

  logic              r_ret_vld;
  logic [REG_W-1:0]  r_ret_num;
  logic [DATA_W-1:0] r_ret_dat;

  logic [DEPTH:1]    w_hit;
  logic              w_hold;
  logic              w_shift;

  // A result only counts when it targets a live, writing slot.
  always_comb begin
    w_hit = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_hit[k] = res_valid_in && (res_slot_in == SLOT_W'(k)) && r_vld[k] && r_wr[k];
    end
  end

  assign w_hold  = r_vld[DEPTH] & r_wr[DEPTH] & ~r_rdy[DEPTH] &
                   ~(res_valid_in && (res_slot_in == SLOT_W'(DEPTH)));
  assign w_shift = advance_in & ~w_hold & ~flush_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld     <= '0;
      r_wr      <= '0;
      r_rdy     <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_num[k] <= '0;
        r_dat[k] <= '0;
      end
      r_ret_vld <= 1'b0;
      r_ret_num <= '0;
      r_ret_dat <= '0;
    end else if (flush_in) begin
      r_vld     <= '0;
      r_rdy     <= '0;
      r_ret_vld <= 1'b0;
    end else if (w_shift) begin
      // Captures ride along with the shift into position k+1.
      for (int k = DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_wr[k]  <= r_wr[k-1];
        r_num[k] <= r_num[k-1];
        r_rdy[k] <= r_rdy[k-1] | w_hit[k-1];
        r_dat[k] <= w_hit[k-1] ? res_data_in : r_dat[k-1];
      end
      r_vld[1]  <= issue_valid_in;
      r_wr[1]   <= issue_write_in;
      r_num[1]  <= issue_num_in;
      r_rdy[1]  <= 1'b0;
      r_dat[1]  <= '0;
      r_ret_vld <= r_vld[DEPTH] & r_wr[DEPTH];
      if (r_vld[DEPTH] && r_wr[DEPTH]) begin
        r_ret_num <= r_num[DEPTH];
        r_ret_dat <= w_hit[DEPTH] ? res_data_in : r_dat[DEPTH];
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (w_hit[k]) begin
          r_rdy[k] <= 1'b1;
          r_dat[k] <= res_data_in;
        end
      end
      r_ret_vld <= 1'b0;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [REG_W-1:0]  w_num;
    logic              w_found;
    logic              w_stall;
    logic [DATA_W-1:0] w_dat;

    assign w_num = rd_num_in[p*REG_W +: REG_W];

    // Scan youngest first; the first match owns the result.
    always_comb begin
      w_found = 1'b0;
      w_stall = 1'b0;
      w_dat   = rd_reg_data_in[p*DATA_W +: DATA_W];
      for (int k = 1; k <= DEPTH; k++) begin
        if (!w_found && r_vld[k] && r_wr[k] && (r_num[k] == w_num) &&
            !((ZERO_REG_EN != 0) && (w_num == '0))) begin
          w_found = 1'b1;
          if (w_hit[k])      w_dat   = res_data_in;
          else if (r_rdy[k]) w_dat   = r_dat[k];
          else               w_stall = 1'b1;
        end
      end
    end

    assign rd_data_out[p*DATA_W +: DATA_W] = w_dat;
    assign rd_stall_out[p]                 = w_stall;
  end

  assign hold_out         = w_hold;
  assign retire_valid_out = r_ret_vld;
  assign retire_num_out   = r_ret_num;
  assign retire_data_out  = r_ret_dat;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default instance plus a ZERO_REG_EN=1 instance on shared inputs.
module tb_fwd_scoreboard;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int D  = 6;
  localparam int NP = 2;
  localparam int SW = $clog2(D) + 1;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             advance_in, flush_in;
  logic             issue_valid_in, issue_write_in;
  logic [RW-1:0]    issue_num_in;
  logic             res_valid_in;
  logic [SW-1:0]    res_slot_in;
  logic [DW-1:0]    res_data_in;
  logic [NP*RW-1:0] rd_num_in;
  logic [NP*DW-1:0] rd_reg_data_in;

  logic [NP*DW-1:0] rd_data_out, z_rd_data_out;
  logic [NP-1:0]    rd_stall_out, z_rd_stall_out;
  logic             hold_out, z_hold_out;
  logic             retire_valid_out, z_retire_valid_out;
  logic [RW-1:0]    retire_num_out, z_retire_num_out;
  logic [DW-1:0]    retire_data_out, z_retire_data_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  fwd_scoreboard #(.DATA_W(DW), .REG_W(RW), .DEPTH(D), .RD_PORTS(NP), .ZERO_REG_EN(0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .advance_in(advance_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_write_in(issue_write_in), .issue_num_in(issue_num_in),
    .res_valid_in(res_valid_in), .res_slot_in(res_slot_in), .res_data_in(res_data_in),
    .rd_num_in(rd_num_in), .rd_reg_data_in(rd_reg_data_in),
    .rd_data_out(rd_data_out), .rd_stall_out(rd_stall_out), .hold_out(hold_out),
    .retire_valid_out(retire_valid_out), .retire_num_out(retire_num_out),
    .retire_data_out(retire_data_out));

  fwd_scoreboard #(.DATA_W(DW), .REG_W(RW), .DEPTH(D), .RD_PORTS(NP), .ZERO_REG_EN(1)) dut_z (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .advance_in(advance_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_write_in(issue_write_in), .issue_num_in(issue_num_in),
    .res_valid_in(res_valid_in), .res_slot_in(res_slot_in), .res_data_in(res_data_in),
    .rd_num_in(rd_num_in), .rd_reg_data_in(rd_reg_data_in),
    .rd_data_out(z_rd_data_out), .rd_stall_out(z_rd_stall_out), .hold_out(z_hold_out),
    .retire_valid_out(z_retire_valid_out), .retire_num_out(z_retire_num_out),
    .retire_data_out(z_retire_data_out));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    advance_in     = 1'b0;
    flush_in       = 1'b0;
    issue_valid_in = 1'b0;
    issue_write_in = 1'b0;
    issue_num_in   = '0;
    res_valid_in   = 1'b0;
    res_slot_in    = '0;
    res_data_in    = '0;
    rd_num_in      = '0;
    rd_reg_data_in = {16'h2222, 16'h1111};
  endtask

  // Inputs change 1ns after the rising edge; checks land mid-cycle.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic issue(input logic [RW-1:0] num);
    issue_valid_in = 1'b1;
    issue_write_in = 1'b1;
    issue_num_in   = num;
    advance_in     = 1'b1;
  endtask

  initial begin
    idle();
    rst_n_in  = 1'b0;
    #1;
    rd_num_in = {3'd5, 3'd3};
    #2;
    chk("rst_p0_data", 32'(rd_data_out[15:0]), 32'h1111);
    chk("rst_stall",   32'(rd_stall_out), 32'h0);
    chk("rst_ret_vld", 32'(retire_valid_out), 32'h0);
    chk("rst_ret_num", 32'(retire_num_out), 32'h0);
    chk("rst_ret_dat", 32'(retire_data_out), 32'h0);
    chk("rst_hold",    32'(hold_out), 32'h0);
    cyc();
    rst_n_in = 1'b1;

    // Single producer: invisible on issue, stall, bypass, then from state.
    cyc(); issue(3'd3); rd_num_in = {3'd5, 3'd3}; #3;
    chk("issue_invisible", 32'(rd_data_out[15:0]), 32'h1111);
    chk("issue_nostall",   32'(rd_stall_out[0]), 32'h0);
    cyc(); rd_num_in = {3'd5, 3'd3}; #3;
    chk("wait_stall", 32'(rd_stall_out[0]), 32'h1);
    chk("wait_data",  32'(rd_data_out[15:0]), 32'h1111);
    cyc(); res_valid_in = 1'b1; res_slot_in = 4'd1; res_data_in = 16'hAAAA; rd_num_in = {3'd5, 3'd3}; #3;
    chk("bypass_data",  32'(rd_data_out[15:0]), 32'hAAAA);
    chk("bypass_stall", 32'(rd_stall_out[0]), 32'h0);
    cyc(); rd_num_in = {3'd5, 3'd3}; #3;
    chk("state_data", 32'(rd_data_out[15:0]), 32'hAAAA);

    // Two producers of r3: the younger one wins even while not ready.
    cyc(); issue(3'd3);
    cyc(); res_valid_in = 1'b1; res_slot_in = 4'd2; res_data_in = 16'h0001; rd_num_in = {3'd5, 3'd3}; #3;
    chk("young_nr_stall", 32'(rd_stall_out[0]), 32'h1);
    cyc(); res_valid_in = 1'b1; res_slot_in = 4'd1; res_data_in = 16'h0002; rd_num_in = {3'd5, 3'd3}; #3;
    chk("young_bypass", 32'(rd_data_out[15:0]), 32'h0002);
    cyc(); rd_num_in = {3'd5, 3'd3}; #3;
    chk("young_state",   32'(rd_data_out[15:0]), 32'h0002);
    chk("nomatch_p1",    32'(rd_data_out[31:16]), 32'h2222);
    chk("two_port_stall", 32'(rd_stall_out), 32'h0);

    // Walk the queue to the oldest slot: retires, then hold on a not-ready entry.
    cyc(); issue(3'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(); advance_in = 1'b1;
    end
    cyc(); advance_in = 1'b1; #3;
    chk("ret1_vld", 32'(retire_valid_out), 32'h1);
    chk("ret1_dat", 32'(retire_data_out), 32'h0001);
    cyc(); advance_in = 1'b1; #3;
    chk("ret2_vld", 32'(retire_valid_out), 32'h1);
    chk("ret2_dat", 32'(retire_data_out), 32'h0002);
    chk("hold_on",  32'(hold_out), 32'h1);
    cyc(); advance_in = 1'b1; rd_num_in = {3'd5, 3'd3}; #3;
    chk("hold_noret",   32'(retire_valid_out), 32'h0);
    chk("hold_still",   32'(hold_out), 32'h1);
    chk("hold_rdstall", 32'(rd_stall_out[0]), 32'h1);
    res_valid_in = 1'b1; res_slot_in = 4'(D); res_data_in = 16'hBEEF; #2;
    chk("hold_release", 32'(hold_out), 32'h0);
    chk("hold_bypass",  32'(rd_data_out[15:0]), 32'hBEEF);
    cyc(); #3;
    chk("ret3_vld", 32'(retire_valid_out), 32'h1);
    chk("ret3_num", 32'(retire_num_out), 32'h3);
    chk("ret3_dat", 32'(retire_data_out), 32'hBEEF);
    cyc(); #3;
    chk("ret3_once", 32'(retire_valid_out), 32'h0);

    // Flush with four live entries plus a competing issue/capture.
    for (int i = 0; i < 4; i++) begin
      cyc(); issue(3'(i + 1));
    end
    cyc(); issue(3'd5); flush_in = 1'b1;
    res_valid_in = 1'b1; res_slot_in = 4'd1; res_data_in = 16'h5555; rd_num_in = {3'd4, 3'd2}; #3;
    chk("preflush_stall", 32'(rd_stall_out), 32'h1);
    chk("preflush_byp",   32'(rd_data_out[31:16]), 32'h5555);
    for (int i = 0; i < D; i++) begin
      cyc(); advance_in = 1'b1; rd_num_in = {3'd5, 3'd2}; #3;
      chk("flush_noret", 32'(retire_valid_out), 32'h0);
      chk("flush_stall", 32'(rd_stall_out), 32'h0);
      chk("flush_data",  32'(rd_data_out), 32'h22221111);
    end

    // Register 0 with no result: masked only on the ZERO_REG_EN instance.
    cyc(); issue(3'd0);
    cyc(); rd_num_in = {3'd3, 3'd0}; rd_reg_data_in = {16'h2222, 16'h1234}; #3;
    chk("zero_data",   32'(z_rd_data_out[15:0]), 32'h1234);
    chk("zero_stall",  32'(z_rd_stall_out[0]), 32'h0);
    chk("r0_nomask",   32'(rd_stall_out[0]), 32'h1);

    // Asynchronous reset mid-cycle clears the pending r0 entry at once.
    rst_n_in = 1'b0; #1;
    chk("arst_stall", 32'(rd_stall_out[0]), 32'h0);
    chk("arst_ret",   32'(retire_valid_out), 32'h0);
    cyc();
    rst_n_in = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised register-forwarding unit for the pipeline that tracks in-flight writes in an internal DEPTH-slot shift queue instead of taking per-stage inputs.
- Captures results as each execution unit produces them, forwards the youngest matching value to RD_PORTS read ports, and raises a stall when the youngest matching producer has no data yet.
- Retires the oldest entry to register-file writeback.
- Sits between decode/issue and the register file.

Parameters:
- DATA_W, 16: data width.
- REG_W, 3: register-number width.
- DEPTH, 6: in-flight slots; slot 1 is youngest, slot DEPTH is oldest.
- RD_PORTS, 2: number of forwarding read ports.
- ZERO_REG_EN, 0: if 1, register 0 is never matched; it always reads from the register file and never stalls.

Ports:
- clk_in, input, 1: clock; all state updates on the rising edge.
- rst_n_in, input, 1: asynchronous active-low reset.
- advance_in, input, 1: pipeline advances this cycle.
- flush_in, input, 1: discard all in-flight entries.
- issue_valid_in, input, 1: instruction issued into slot 1 on advance.
- issue_write_in, input, 1: issued instruction writes a register.
- issue_num_in, input, REG_W: destination register number.
- res_valid_in, input, 1: result available this cycle.
- res_slot_in, input, clog2(DEPTH)+1: pre-shift slot index of the producer (1..DEPTH).
- res_data_in, input, DATA_W: result value.
- rd_num_in, input, RD_PORTS*REG_W: source register number per port; port p occupies bits [p*REG_W +: REG_W].
- rd_reg_data_in, input, RD_PORTS*DATA_W: register-file value per port.
- rd_data_out, output, RD_PORTS*DATA_W: forwarded value per port.
- rd_stall_out, output, RD_PORTS: per-port data-not-ready.
- hold_out, output, 1: oldest entry not ready; shift suppressed.
- retire_valid_out, output, 1: registered writeback strobe.
- retire_num_out, output, REG_W: writeback register number.
- retire_data_out, output, DATA_W: writeback data.

Behaviour:
- Slot state: valid, write, num, ready, data.
- Reset: all slot valid/ready = 0; retire_valid_out = 0; retire_num_out = 0; retire_data_out = 0. rd_data_out equals rd_reg_data_in; rd_stall_out = 0; hold_out = 0.
- hold_out: combinational, = slot DEPTH valid & write & !ready & !(res_valid_in & res_slot_in==DEPTH).
- Shift: occurs when advance_in & !hold_out & !flush_in.
  - Slot k moves to k+1.
  - Slot 1 loads {issue_valid_in, issue_write_in, issue_num_in, ready=0}.
  - Slot DEPTH leaves the queue. If it was valid & write, then next cycle retire_valid_out = 1, with its num and data (same-cycle result bypassed in). Otherwise retire_valid_out = 0.
- No shift (advance_in = 0 or hold_out = 1): slots hold; the issue input is ignored; retire_valid_out = 0 next cycle.
- Result capture:
  - Applies when res_valid_in and slot res_slot_in is valid & write: ready <= 1 and data <= res_data_in.
  - Capture lands in post-shift position k+1 if a shift occurs, else slot k.
  - Captures to invalid slots, non-writing slots, or out-of-range indices are ignored.
  - A capture to slot DEPTH during a shift goes directly to retire.
- Flush: all valid <= 0 next cycle. It takes priority over shift, issue and capture. A retire already registered in the previous cycle still appears; no new retire is produced from the flush cycle.
- Lookup per port p, combinational:
  - Match on slot k: valid & write & num==rd_num_p, and not (ZERO_REG_EN & rd_num_p==0).
  - The lowest-index (youngest) matching slot wins.
  - Winner ready, or same-cycle res bypass to that slot: rd_data_out = its data (bypass data takes precedence); stall = 0.
  - Winner not ready: stall = 1; rd_data_out = rd_reg_data_in (don't-care value, but defined).
  - No match: rd_data_out = rd_reg_data_in; stall = 0.
  - Lookup uses pre-edge state; the entry issued this cycle is not visible.
- Reset asserted mid-operation: queue cleared immediately (asynchronous); any pending retire is dropped.
- Latency:
  - Forwarding and stall: 0 cycles.
  - Retire: 1 cycle after the shift that ejects the entry.
  - Result visibility: same cycle via bypass, thereafter from slot state.

Test Plan:
- Reset, then read r3 with rd_reg_data_in=0x1111 -> rd_data_out=0x1111, stall=0, retire_valid_out=0.
- Issue write r3, advance; next cycle res slot1=0xAAAA -> same-cycle rd r3=0xAAAA, stall=0; the cycle before the result arrives gives stall=1.
- Issue r3 (data 0x0001) then r3 again (data 0x0002, slot 1) -> read r3 returns 0x0002 (youngest priority); both ports reading r3 and r5 (no match) return 0x0002 and the regfile value.
- Advance DEPTH+1 times with slot-DEPTH entry not ready -> hold_out=1, no shift, no retire; supply res slot DEPTH=0xBEEF with advance -> next cycle retire_valid_out=1, num=r3, data=0xBEEF.
- flush_in with 4 valid entries and issue_valid_in=1 -> all reads return regfile values, no retire for the following DEPTH advances.
- ZERO_REG_EN=1, issue write r0 and produce no result -> read r0 gives rd_reg_data_in, stall=0.
